// File: rtl/sm_fetch_pkg.sv
// rtl/sm_fetch_pkg.sv - shared types for the sm_fetch instruction prefetch stage
package sm_fetch_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/sm_fetch_if.sv
// rtl/sm_fetch_if.sv - memory-side and consumer-side handshake bundle of sm_fetch
interface sm_fetch_if;

  logic        imReq;
  logic [31:0] imAddr;
  logic        imAck;
  logic [31:0] imData;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrReady;
  logic        redirect;
  logic [31:0] redirectPc;

  modport master (
    output imReq, imAddr, instrValid, instr, instrPc,
    input  imAck, imData, instrReady, redirect, redirectPc
  );

  modport slave (
    input  imReq, imAddr, instrValid, instr, instrPc,
    output imAck, imData, instrReady, redirect, redirectPc
  );

endinterface

// File: rtl/sm_fetch_fifo.sv
// rtl/sm_fetch_fifo.sv - DEPTH-entry {pc, instr} FIFO with registered head and flush
module sm_fetch_fifo
  import sm_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head is read straight out of storage, so a push shows up one cycle later.
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/sm_fetch.sv
// rtl/sm_fetch.sv - instruction prefetch: fetch FSM, fetch PC and FIFO credit control
module sm_fetch
  import sm_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic      clk,
  input logic      rst,
  sm_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   im_addr_q, im_addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  fetch_entry_t  push_data;
  fetch_entry_t  head;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   count_after;
  logic          fifo_full;
  logic          fifo_empty;
  logic          im_req;
  logic          push;
  logic          pop;
  logic          flush;
  logic          slot_free;

  // Requests are suppressed while rst is high so nothing is issued during reset.
  assign im_req    = (state_q != FETCH_IDLE) && !rst;
  assign flush     = bus.redirect;
  assign pop       = !fifo_empty && bus.instrReady && !bus.redirect;
  assign push      = (state_q == FETCH_REQ) && bus.imAck && !bus.redirect && !rst;
  assign push_data = '{pc: im_addr_q, instr: bus.imData};

  assign count_after = {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop);
  assign slot_free   = count_after < (CW+1)'(DEPTH);

  always_comb begin
    state_d    = state_q;
    im_addr_d  = im_addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      FETCH_IDLE: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirectPc;
          im_addr_d  = bus.redirectPc;
          state_d    = FETCH_REQ;
        end else if (!fifo_full || pop) begin
          im_addr_d = fetch_pc_q;
          state_d   = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirectPc;
          if (bus.imAck) begin
            im_addr_d = bus.redirectPc;
          end else begin
            state_d = FETCH_DISCARD;
          end
        end else if (bus.imAck) begin
          fetch_pc_d = next_pc(fetch_pc_q);
          im_addr_d  = next_pc(fetch_pc_q);
          state_d    = slot_free ? FETCH_REQ : FETCH_IDLE;
        end
      end
      FETCH_DISCARD: begin
        // imAddr stays on the flushed address; fetch_pc holds the latest target.
        if (bus.redirect) begin
          fetch_pc_d = bus.redirectPc;
        end
        if (bus.imAck) begin
          im_addr_d = bus.redirect ? bus.redirectPc : fetch_pc_q;
          state_d   = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_REQ;
      im_addr_q  <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      im_addr_q  <= im_addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  sm_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.imReq      = im_req;
  assign bus.imAddr     = im_addr_q;
  assign bus.instrValid = !fifo_empty;
  assign bus.instr      = head.instr;
  assign bus.instrPc    = head.pc;

endmodule

// File: tb/tb_sm_fetch.sv
// tb/tb_sm_fetch.sv - directed vector bench for sm_fetch (DEPTH=4, RESET_PC=0)
module tb_sm_fetch;

  logic clk;
  logic rst;
  logic bad_data;
  int   total;
  int   bad;

  sm_fetch_if bus();

  sm_fetch #(
    .DEPTH    (4),
    .RESET_PC (32'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb bus.imData = bad_data ? 32'hDEAD_BEEF : mem_word(bus.imAddr);

  typedef struct {
    logic        r;
    logic        ack;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        bd;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  function automatic vec_t mk(input logic r, ack, rdy, redir, input logic [31:0] rpc,
                              input logic bd, ereq, input logic [31:0] eaddr,
                              input logic evalid, input logic [31:0] epc);
    vec_t v;
    v.r = r; v.ack = ack; v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.bd = bd;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the outputs of that cycle, then clock.
  task automatic run(input vec_t v, input string tag);
    rst            = v.r;
    bus.imAck      = v.ack;
    bus.instrReady = v.rdy;
    bus.redirect   = v.redir;
    bus.redirectPc = v.rpc;
    bad_data       = v.bd;
    #1;
    chk({tag, ".imReq"}, {31'd0, bus.imReq}, {31'd0, v.ereq});
    if (v.ereq) chk({tag, ".imAddr"}, bus.imAddr, v.eaddr);
    chk({tag, ".instrValid"}, {31'd0, bus.instrValid}, {31'd0, v.evalid});
    if (v.evalid) begin
      chk({tag, ".instrPc"}, bus.instrPc, v.epc);
      chk({tag, ".instr"}, bus.instr, mem_word(v.epc));
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vt [18];

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; bad_data = 1'b0;
    bus.imAck = 1'b0; bus.instrReady = 1'b0; bus.redirect = 1'b0; bus.redirectPc = '0;
    @(posedge clk);
    #1;
    chk("rst.imReq", {31'd0, bus.imReq}, 32'd0);
    chk("rst.imAddr", bus.imAddr, 32'd0);
    chk("rst.instrValid", {31'd0, bus.instrValid}, 32'd0);
    chk("rst.instr", bus.instr, 32'd0);
    chk("rst.instrPc", bus.instrPc, 32'd0);

    //          r  ack rdy rd rpc bd req addr v  pc
    vt[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    vt[2]  = mk(0, 1, 1, 0, 0, 0, 1, 1, 1, 0);
    vt[3]  = mk(0, 1, 1, 0, 0, 0, 1, 2, 1, 1);
    vt[4]  = mk(0, 1, 1, 0, 0, 0, 1, 3, 1, 2);
    vt[5]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 3);
    vt[6]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[7]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[8]  = mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 0);
    vt[9]  = mk(0, 1, 0, 0, 0, 0, 1, 2, 1, 0);
    vt[10] = mk(0, 1, 0, 0, 0, 0, 1, 3, 1, 0);
    vt[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[13] = mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    vt[14] = mk(0, 1, 1, 0, 0, 0, 1, 4, 1, 1);
    vt[15] = mk(0, 1, 1, 0, 0, 0, 1, 5, 1, 2);
    vt[16] = mk(0, 1, 1, 0, 0, 0, 1, 6, 1, 3);
    vt[17] = mk(0, 1, 1, 0, 0, 0, 1, 7, 1, 4);
    for (int i = 0; i < 18; i++) begin
      run(vt[i], $sformatf("vec%0d", i));
    end

    // wait states: address held until ack, one push
    run(mk(0, 0, 1, 0, 0, 0, 1, 8, 1, 5), "ws1");
    run(mk(0, 0, 1, 0, 0, 0, 1, 8, 1, 6), "ws2");
    run(mk(0, 0, 1, 0, 0, 0, 1, 8, 1, 7), "ws3");
    run(mk(0, 1, 1, 0, 0, 0, 1, 8, 0, 0), "ws4");
    run(mk(0, 0, 1, 0, 0, 0, 1, 9, 1, 8), "ws5");
    run(mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 0), "ws6");

    // redirect with 3 entries buffered, coinciding with an ack
    run(mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0), "rd1");
    run(mk(0, 1, 0, 0, 0, 0, 1, 10, 1, 9), "rd2");
    run(mk(0, 1, 0, 0, 0, 0, 1, 11, 1, 9), "rd3");
    run(mk(0, 1, 0, 1, 32'h40, 0, 1, 12, 1, 9), "rd4");
    run(mk(0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0), "rd5");
    run(mk(0, 1, 1, 0, 0, 0, 1, 32'h40, 0, 0), "rd6");
    run(mk(0, 0, 1, 0, 0, 0, 1, 32'h41, 1, 32'h40), "rd7");

    // redirect with a request in flight, then a second redirect during discard
    run(mk(0, 0, 1, 1, 32'h40, 0, 1, 32'h41, 0, 0), "dc1");
    run(mk(0, 0, 1, 0, 0, 0, 1, 32'h41, 0, 0), "dc2");
    run(mk(0, 1, 1, 0, 0, 1, 1, 32'h41, 0, 0), "dc3");
    run(mk(0, 0, 1, 0, 0, 0, 1, 32'h40, 0, 0), "dc4");
    run(mk(0, 0, 1, 1, 32'h70, 0, 1, 32'h40, 0, 0), "dc5");
    run(mk(0, 0, 1, 1, 32'h80, 0, 1, 32'h40, 0, 0), "dc6");
    run(mk(0, 1, 1, 0, 0, 1, 1, 32'h40, 0, 0), "dc7");
    run(mk(0, 1, 0, 0, 0, 0, 1, 32'h80, 0, 0), "dc8");
    run(mk(0, 1, 0, 0, 0, 0, 1, 32'h81, 1, 32'h80), "dc9");

    // fill to full, then redirect from idle
    run(mk(0, 1, 0, 0, 0, 0, 1, 32'h82, 1, 32'h80), "id1");
    run(mk(0, 1, 0, 0, 0, 0, 1, 32'h83, 1, 32'h80), "id2");
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80), "id3");
    run(mk(0, 0, 0, 1, 32'h100, 0, 0, 0, 1, 32'h80), "id4");
    run(mk(0, 1, 0, 0, 0, 0, 1, 32'h100, 0, 0), "id5");
    run(mk(0, 1, 0, 0, 0, 0, 1, 32'h101, 1, 32'h100), "id6");
    run(mk(0, 1, 0, 0, 0, 0, 1, 32'h102, 1, 32'h100), "id7");
    run(mk(0, 0, 0, 0, 0, 0, 1, 32'h103, 1, 32'h100), "id8");

    // reset mid-operation with entries buffered and a request pending
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100), "mr1");
    run(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0), "mr2");
    run(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 0), "mr3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
